// File: rtl/riscv_boot_ctrl.sv
// riscv_boot_ctrl: loads a length-prefixed byte stream into instruction memory, then releases the CPU reset.
module riscv_boot_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam logic [2:0] HDR0  = 3'd0;
  localparam logic [2:0] HDR1  = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] RUN   = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;
  localparam logic [16:0] CAP  = 17'd1 << ADDR_W;
  logic [2:0]        state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       buf_q, buf_d;
  logic              xfer, last_word;
  logic [16:0]       n_full;
  assign xfer      = rx_valid && rx_ready;
  // 17-bit so that N == 2^ADDR_W is accepted and fills memory exactly
  assign n_full    = {1'b0, rx_data, n_q[7:0]};
  assign last_word = 16'(word_idx_q) == n_q - 16'd1;
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    buf_d      = buf_q;
    case (state_q)
      HDR0: if (xfer) begin
        n_d[7:0] = rx_data;
        state_d  = HDR1;
      end
      HDR1: if (xfer) begin
        n_d[15:8]  = rx_data;
        word_idx_d = '0;
        byte_idx_d = '0;
        state_d    = n_full == 17'd0 ? RUN : n_full > CAP ? ERR : DATA;
      end
      DATA: if (xfer) begin
        buf_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
        byte_idx_d = byte_idx_q + 2'd1;
        state_d    = byte_idx_q == 2'd3 ? WRITE : DATA;
      end
      WRITE: begin
        state_d    = last_word ? RUN : DATA;
        word_idx_d = last_word ? word_idx_q : word_idx_q + ADDR_W'(1);
      end
      RUN, ERR: state_d = restart ? HDR0 : state_q;
      default: state_d = HDR0;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HDR0;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      buf_q      <= buf_d;
    end
  end
  assign rx_ready   = state_q == HDR0 || state_q == HDR1 || state_q == DATA;
  assign imem_we    = state_q == WRITE;
  assign imem_addr  = imem_we ? word_idx_q : '0;
  assign imem_wdata = imem_we ? buf_q : '0;
  assign cpu_reset  = state_q != RUN;
  assign busy       = state_q == HDR1 || state_q == DATA || state_q == WRITE;
  assign done       = state_q == RUN;
  assign error      = state_q == ERR;
endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// tb_riscv_boot_ctrl: scoreboard bench; expected writes are queued by the stimulus and popped by a write monitor.
module tb_riscv_boot_ctrl;
  logic       clk = 1'b0, reset = 1'b1, restart = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready, imem_we, cpu_reset, busy, done, error;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  int compared = 0, mismatched = 0;
  typedef struct {logic [7:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];

  riscv_boot_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .restart(restart), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: addr %h data %h at %0t", imem_addr, imem_wdata, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.a));
        chk("wr_data", imem_wdata, e.d);
      end
    end
  end

  // Called at posedge+1; holds the byte until it transfers on a rising edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!rx_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: rx_ready stuck 0 for byte %h", b);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int j = 0; j < 4; j++) begin
      if (gaps) idle($urandom_range(0, 2));
      send(w[8*j +: 8]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  function automatic logic [31:0] word_of(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b + 8'd1, ~b, b ^ 8'h5A, b};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #12 reset = 1'b0;
    @(posedge clk);
    #1;
    // async reset mid-cycle from HDR1
    send(8'h05);
    chk("hdr1_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_rx_ready", 32'(rx_ready), 1);
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    // two-word load
    exp_q.push_back('{8'd0, 32'h00100513});
    exp_q.push_back('{8'd1, 32'h00200593});
    send(8'h02);
    send(8'h00);
    send(8'h13);
    chk("idle_addr", 32'(imem_addr), 0);
    chk("idle_wdata", imem_wdata, 0);
    send(8'h05);
    send(8'h10);
    send(8'h00);
    send_word(32'h00200593, 1'b0);
    chk("last_we", 32'(imem_we), 1);
    chk("last_rx_ready", 32'(rx_ready), 0);
    chk("cpu_reset_hold", 32'(cpu_reset), 1);
    idle(1);
    chk("run_cpu_reset", 32'(cpu_reset), 0);
    chk("run_done", 32'(done), 1);
    chk("run_busy", 32'(busy), 0);
    // restart with a valid byte in the same cycle, then gapped reload
    rx_data  = 8'h02;
    rx_valid = 1'b1;
    pulse_restart();
    chk("restart_cpu_reset", 32'(cpu_reset), 1);
    chk("restart_rx_ready", 32'(rx_ready), 1);
    chk("restart_done", 32'(done), 0);
    exp_q.push_back('{8'd0, 32'h00100513});
    exp_q.push_back('{8'd1, 32'h00200593});
    send(8'h02);
    idle(2);
    send(8'h00);
    send_word(32'h00100513, 1'b1);
    send_word(32'h00200593, 1'b1);
    idle(1);
    chk("gap_done", 32'(done), 1);
    // empty program
    do_reset();
    send(8'h00);
    chk("empty_cpu_reset_hdr1", 32'(cpu_reset), 1);
    send(8'h00);
    chk("empty_done", 32'(done), 1);
    chk("empty_cpu_reset", 32'(cpu_reset), 0);
    // oversize headers
    do_reset();
    send(8'h2C);
    send(8'h01);
    chk("n300_error", 32'(error), 1);
    chk("n300_cpu_reset", 32'(cpu_reset), 1);
    chk("n300_rx_ready", 32'(rx_ready), 0);
    chk("n300_busy", 32'(busy), 0);
    pulse_restart();
    chk("err_restart_error", 32'(error), 0);
    chk("err_restart_rx_ready", 32'(rx_ready), 1);
    send(8'h01);
    send(8'h01);
    chk("n257_error", 32'(error), 1);
    pulse_restart();
    exp_q.push_back('{8'd0, 32'hDEADBEEF});
    send(8'h01);
    send(8'h00);
    send_word(32'hDEADBEEF, 1'b0);
    idle(1);
    chk("after_err_done", 32'(done), 1);
    // capacity edge: 256 words
    pulse_restart();
    send(8'h00);
    send(8'h01);
    chk("n256_busy", 32'(busy), 1);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back('{8'(i), word_of(i)});
      send_word(word_of(i), 1'b0);
    end
    idle(1);
    chk("n256_done", 32'(done), 1);
    chk("n256_all_written", 32'(exp_q.size()), 0);
    // reset mid-word, then reload
    pulse_restart();
    exp_q.push_back('{8'd0, 32'hCAFEF00D});
    send(8'h02);
    send(8'h00);
    send_word(32'hCAFEF00D, 1'b0);
    send(8'h11);
    send(8'h22);
    #2 reset = 1'b1;
    #1;
    chk("midword_rst_busy", 32'(busy), 0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back('{8'd0, 32'h12345678});
    send(8'h01);
    send(8'h00);
    send_word(32'h12345678, 1'b1);
    idle(1);
    chk("reload_done", 32'(done), 1);
    idle(2);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
